// File: rtl/operand_fetch_pkg.sv
// Shared widths and sizes for the operand fetch stage and its scoreboard.
package operand_fetch_pkg;
  localparam int REG_COUNT          = 32;
  localparam int REG_ADDR_WIDTH     = 5;
  localparam int REGFILE_ADDR_WIDTH = 6;
  localparam int DATA_WIDTH         = 32;
endpackage

// File: rtl/operand_fetch_if.sv
// Decode, regfile, writeback and execute-side signals seen by operand_fetch.
interface operand_fetch_if
  import operand_fetch_pkg::*;
();
  logic                          in_valid;
  logic                          in_ready;
  logic [REG_ADDR_WIDTH-1:0]     in_rs1;
  logic [REG_ADDR_WIDTH-1:0]     in_rs2;
  logic [REG_ADDR_WIDTH-1:0]     in_rd;
  logic                          in_rd_write;
  logic [REGFILE_ADDR_WIDTH-1:0] address_read_1;
  logic [REGFILE_ADDR_WIDTH-1:0] address_read_2;
  logic [DATA_WIDTH-1:0]         read_data_1;
  logic [DATA_WIDTH-1:0]         read_data_2;
  logic                          wb_valid;
  logic [REG_ADDR_WIDTH-1:0]     wb_rd;
  logic [DATA_WIDTH-1:0]         wb_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_operand_1;
  logic [DATA_WIDTH-1:0]         out_operand_2;
  logic [REG_ADDR_WIDTH-1:0]     out_rd;
  logic                          out_rd_write;

  // The surrounding pipeline (decode, regfile, writeback, execute).
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_write,
    output read_data_1, read_data_2,
    output wb_valid, wb_rd, wb_data,
    output out_ready,
    input  in_ready, address_read_1, address_read_2,
    input  out_valid, out_operand_1, out_operand_2, out_rd, out_rd_write
  );

  // The operand fetch stage itself.
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_write,
    input  read_data_1, read_data_2,
    input  wb_valid, wb_rd, wb_data,
    input  out_ready,
    output in_ready, address_read_1, address_read_2,
    output out_valid, out_operand_1, out_operand_2, out_rd, out_rd_write
  );
endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Register busy tracking: a bit is set when a writer issues and cleared on its writeback.
module scoreboard
  import operand_fetch_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      set_en,
  input  logic [REG_ADDR_WIDTH-1:0] set_rd,
  output logic                      busy_rs1,
  output logic                      busy_rs2,
  output logic                      busy_rd
);

  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;

  // A register being written back this cycle is already free for readers.
  function automatic logic eff_busy(input logic [REG_COUNT-1:0] busy,
                                    input logic [REG_ADDR_WIDTH-1:0] r,
                                    input logic wbv,
                                    input logic [REG_ADDR_WIDTH-1:0] wbr);
    return busy[r] && !(wbv && (wbr == r));
  endfunction

  always_comb begin
    busy_rs1 = eff_busy(busy_q, rs1, wb_valid, wb_rd);
    busy_rs2 = eff_busy(busy_q, rs2, wb_valid, wb_rd);
    busy_rd  = eff_busy(busy_q, rd,  wb_valid, wb_rd);
  end

  // Clear first so a same-edge set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid && (wb_rd != '0))
      busy_d[wb_rd] = 1'b0;
    if (set_en)
      busy_d[set_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: hazard-gated issue, writeback forwarding, one-deep output register.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  operand_fetch_if.slave bus
);

  logic                      busy_rs1;
  logic                      busy_rs2;
  logic                      busy_rd;
  logic                      hazard;
  logic                      in_ready_p0;
  logic                      accept;
  logic                      set_en;
  logic [DATA_WIDTH-1:0]     op1_p0;
  logic [DATA_WIDTH-1:0]     op2_p0;

  logic                      vld_p1;
  logic [DATA_WIDTH-1:0]     op1_p1;
  logic [DATA_WIDTH-1:0]     op2_p1;
  logic [REG_ADDR_WIDTH-1:0] rd_p1;
  logic                      rd_write_p1;

  // x0 is hardwired zero; otherwise a same-cycle writeback beats the stale regfile read.
  function automatic logic [DATA_WIDTH-1:0] fwd_operand(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic [DATA_WIDTH-1:0]     rf_data,
    input logic                      wbv,
    input logic [REG_ADDR_WIDTH-1:0] wbr,
    input logic [DATA_WIDTH-1:0]     wbd
  );
    if (rs == '0)
      return '0;
    else if (wbv && (wbr == rs))
      return wbd;
    else
      return rf_data;
  endfunction

  scoreboard u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .rs1      (bus.in_rs1),
    .rs2      (bus.in_rs2),
    .rd       (bus.in_rd),
    .wb_valid (bus.wb_valid),
    .wb_rd    (bus.wb_rd),
    .set_en   (set_en),
    .set_rd   (bus.in_rd),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2),
    .busy_rd  (busy_rd)
  );

  // Stage p0: hazard check, handshake and operand selection
  always_comb begin
    hazard      = bus.in_valid &&
                  (busy_rs1 || busy_rs2 || (bus.in_rd_write && busy_rd));
    in_ready_p0 = reset && !hazard && (!vld_p1 || bus.out_ready);
    accept      = bus.in_valid && in_ready_p0;
    set_en      = accept && bus.in_rd_write && (bus.in_rd != '0);
    op1_p0      = fwd_operand(bus.in_rs1, bus.read_data_1, bus.wb_valid, bus.wb_rd, bus.wb_data);
    op2_p0      = fwd_operand(bus.in_rs2, bus.read_data_2, bus.wb_valid, bus.wb_rd, bus.wb_data);
  end

  assign bus.in_ready       = in_ready_p0;
  assign bus.address_read_1 = {1'b0, bus.in_rs1};
  assign bus.address_read_2 = {1'b0, bus.in_rs2};

  // Stage p1: output bundle register, held while execute stalls
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_p1      <= 1'b0;
      rd_write_p1 <= 1'b0;
      op1_p1      <= '0;
      op2_p1      <= '0;
      rd_p1       <= '0;
    end else if (accept) begin
      vld_p1      <= 1'b1;
      rd_write_p1 <= bus.in_rd_write && (bus.in_rd != '0);
      op1_p1      <= op1_p0;
      op2_p1      <= op2_p0;
      rd_p1       <= bus.in_rd;
    end else if (bus.out_ready) begin
      vld_p1      <= 1'b0;
    end
  end

  assign bus.out_valid     = vld_p1;
  assign bus.out_operand_1 = op1_p1;
  assign bus.out_operand_2 = op2_p1;
  assign bus.out_rd        = rd_p1;
  assign bus.out_rd_write  = rd_write_p1;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: hazards, forwarding, stalls and reset.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  operand_fetch_if bus ();

  operand_fetch dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_instr(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic rdw);
    bus.in_valid    = v;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_rd       = rd;
    bus.in_rd_write = rdw;
  endtask

  task automatic drive_wb(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.wb_valid = v;
    bus.wb_rd    = r;
    bus.wb_data  = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_instr(1'b1, 5'd3, 5'd4, 5'd5, 1'b1);
    drive_wb(1'b0, 5'd0, 32'h0);
    bus.read_data_1 = 32'h11;
    bus.read_data_2 = 32'h22;
    bus.out_ready   = 1'b1;
    step();
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_rd_write !== 1'b0) begin failures++; $display("FAIL reset_out_rd_write got=%b exp=0", bus.out_rd_write); end
    checks++; if (bus.out_operand_1 !== 32'h0) begin failures++; $display("FAIL reset_operand_1 got=%h exp=0", bus.out_operand_1); end
    checks++; if (bus.out_rd !== 5'd0) begin failures++; $display("FAIL reset_out_rd got=%0d exp=0", bus.out_rd); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    drive_instr(1'b1, 5'd3, 5'd4, 5'd5, 1'b1);
    bus.read_data_1 = 32'h11;
    bus.read_data_2 = 32'h22;
    #1;
    checks++; if (bus.address_read_1 !== 6'd3) begin failures++; $display("FAIL addr_read_1 got=%0d exp=3", bus.address_read_1); end
    checks++; if (bus.address_read_2 !== 6'd4) begin failures++; $display("FAIL addr_read_2 got=%0d exp=4", bus.address_read_2); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready got=%b exp=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_operand_1 !== 32'h11) begin failures++; $display("FAIL basic_operand_1 got=%h exp=11", bus.out_operand_1); end
    checks++; if (bus.out_operand_2 !== 32'h22) begin failures++; $display("FAIL basic_operand_2 got=%h exp=22", bus.out_operand_2); end
    checks++; if (bus.out_rd !== 5'd5) begin failures++; $display("FAIL basic_out_rd got=%0d exp=5", bus.out_rd); end
    checks++; if (bus.out_rd_write !== 1'b1) begin failures++; $display("FAIL basic_out_rd_write got=%b exp=1", bus.out_rd_write); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL drain_out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_raw();
    drive_instr(1'b1, 5'd5, 5'd4, 5'd6, 1'b0);
    bus.read_data_1 = 32'h55;
    bus.read_data_2 = 32'h22;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL raw_stall0_in_ready got=%b exp=0", bus.in_ready); end
    step();
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL raw_stall1_in_ready got=%b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL raw_stall_out_valid got=%b exp=0", bus.out_valid); end
    drive_wb(1'b1, 5'd5, 32'hDEAD);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL raw_wb_in_ready got=%b exp=1", bus.in_ready); end
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL raw_out_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_operand_1 !== 32'hDEAD) begin failures++; $display("FAIL raw_forward_op1 got=%h exp=dead", bus.out_operand_1); end
    checks++; if (bus.out_operand_2 !== 32'h22) begin failures++; $display("FAIL raw_op2 got=%h exp=22", bus.out_operand_2); end
    drive_instr(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL raw_cleared_in_ready got=%b exp=1", bus.in_ready); end
    bus.in_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_zero();
    drive_instr(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    bus.read_data_1 = 32'hFFFF_FFFF;
    bus.read_data_2 = 32'hFFFF_FFFF;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL zero_in_ready got=%b exp=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_operand_1 !== 32'h0) begin failures++; $display("FAIL zero_op1 got=%h exp=0", bus.out_operand_1); end
    checks++; if (bus.out_operand_2 !== 32'h0) begin failures++; $display("FAIL zero_op2 got=%h exp=0", bus.out_operand_2); end
    checks++; if (bus.out_rd_write !== 1'b0) begin failures++; $display("FAIL zero_rd_write got=%b exp=0", bus.out_rd_write); end
    drive_instr(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL zero_no_busy got=%b exp=1", bus.in_ready); end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    drive_instr(1'b1, 5'd1, 5'd2, 5'd10, 1'b0);
    bus.read_data_1 = 32'hA1;
    bus.read_data_2 = 32'hA2;
    step();
    drive_instr(1'b1, 5'd11, 5'd12, 5'd13, 1'b0);
    bus.read_data_1 = 32'hB1;
    bus.read_data_2 = 32'hB2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid cyc=%0d got=%b exp=1", i, bus.out_valid); end
      checks++; if (bus.out_operand_1 !== 32'hA1 || bus.out_operand_2 !== 32'hA2 || bus.out_rd !== 5'd10)
        begin failures++; $display("FAIL stall_hold cyc=%0d got=%h/%h/%0d exp=a1/a2/10", i, bus.out_operand_1, bus.out_operand_2, bus.out_rd); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_out_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_operand_1 !== 32'hB1 || bus.out_operand_2 !== 32'hB2 || bus.out_rd !== 5'd13)
      begin failures++; $display("FAIL b2b_bundle got=%h/%h/%0d exp=b1/b2/13", bus.out_operand_1, bus.out_operand_2, bus.out_rd); end
    step();
  endtask

  task automatic test_same_edge();
    drive_instr(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
    drive_wb(1'b1, 5'd7, 32'h77);
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_instr(1'b1, 5'd7, 5'd2, 5'd3, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL same_edge_busy7 got=%b exp=0", bus.in_ready); end
    drive_instr(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL waw_in_ready got=%b exp=0", bus.in_ready); end
    drive_instr(1'b1, 5'd1, 5'd2, 5'd7, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL no_waw_in_ready got=%b exp=1", bus.in_ready); end
    bus.in_valid = 1'b0;
    drive_wb(1'b1, 5'd20, 32'h20);
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
    drive_instr(1'b1, 5'd20, 5'd0, 5'd0, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL harmless_wb got=%b exp=1", bus.in_ready); end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_stall();
    bus.out_ready = 1'b0;
    drive_instr(1'b1, 5'd1, 5'd2, 5'd9, 1'b1);
    step();
    drive_instr(1'b1, 5'd9, 5'd7, 5'd0, 1'b0);
    bus.read_data_1 = 32'h99;
    bus.read_data_2 = 32'h98;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL pre_reset_in_ready got=%b exp=0", bus.in_ready); end
    reset = 1'b0;
    drive_wb(1'b1, 5'd9, 32'h1234);
    step();
    drive_wb(1'b0, 5'd0, 32'h0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_stall_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_low_in_ready got=%b exp=0", bus.in_ready); end
    reset = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL post_reset_out_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_operand_1 !== 32'h99 || bus.out_operand_2 !== 32'h98)
      begin failures++; $display("FAIL post_reset_ops got=%h/%h exp=99/98", bus.out_operand_1, bus.out_operand_2); end
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive_instr(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    drive_wb(1'b0, 5'd0, 32'h0);
    bus.read_data_1 = 32'h0;
    bus.read_data_2 = 32'h0;
    bus.out_ready   = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_raw();
    test_zero();
    test_stall();
    test_same_edge();
    test_reset_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL be clocked by the single clock port `clock`; reset is synchronous and active-low.
REQ-002 The ports SHALL be as follows (name  direction  width  meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this edge if in_valid
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_rd  in  5  destination register
- in_rd_write  in  1  instruction writes in_rd
- address_read_1  out  6  regfile read address 1
- address_read_2  out  6  regfile read address 2
- read_data_1  in  32  regfile read data 1 (combinational)
- read_data_2  in  32  regfile read data 2 (combinational)
- wb_valid  in  1  writeback occurring this cycle (same cycle as regfile write_enable)
- wb_rd  in  5  writeback register
- wb_data  in  32  writeback data
- out_valid  out  1  operand bundle valid
- out_ready  in  1  execute stage accepts bundle
- out_operand_1  out  32  resolved operand 1
- out_operand_2  out  32  resolved operand 2
- out_rd  out  5  registered in_rd
- out_rd_write  out  1  registered in_rd_write, forced 0 when in_rd==0

Function
REQ-003 address_read_1/2 SHALL equal {1'b0, in_rs1}/{1'b0, in_rs2}, combinationally, every cycle.
REQ-004 The scoreboard SHALL be a 32-bit busy vector; busy[0] SHALL read 0 at all times.
REQ-005 The effective busy state of reg r SHALL be busy[r] && !(wb_valid && wb_rd==r).
REQ-006 A hazard SHALL exist when in_valid and the effective busy state holds for in_rs1, for in_rs2, or (when in_rd_write=1) for in_rd (WAW).
REQ-007 in_ready SHALL be !hazard && (!out_valid || out_ready).
REQ-008 Accept SHALL be in_valid && in_ready; on accept, the output register SHALL load at that edge, giving out_valid=1 one cycle after accept (latency 1).
REQ-009 Operand n SHALL be forwarded: if wb_valid && wb_rd==in_rsn && in_rsn!=0, use wb_data; if in_rsn==0, use 0; otherwise use read_data_n.
REQ-010 When accepting with in_rd_write=1 and in_rd!=0, the block SHALL set busy[in_rd].
REQ-011 When wb_valid=1 and wb_rd!=0, the block SHALL clear busy[wb_rd]; wb_rd==0 SHALL be ignored.
REQ-012 When a set and a clear target the same register on the same edge, the set SHALL win.
REQ-013 While out_valid && !out_ready, all out_* signals SHALL hold stable.
REQ-014 When out_valid && out_ready and there is no accept, out_valid SHALL fall to 0 at the next edge.
REQ-015 Simultaneous output drain and new accept SHALL give back-to-back bundles with no bubble.
REQ-016 A writeback to a register with busy=0 SHALL be harmless and leave the bit clear.

Reset
REQ-017 On reset=0 at a rising edge, out_valid, out_rd_write and the busy vector SHALL clear to 0, and out_operand_1/2 and out_rd SHALL clear to 0.
REQ-018 Reset mid-stall SHALL discard the held bundle and all busy bits; wb_valid in the reset cycle SHALL have no effect.
REQ-019 in_ready SHALL be 0 while reset=0.

Structure
REQ-020 The shared package SHALL hold: REG_COUNT=32, REG_ADDR_WIDTH=5, REGFILE_ADDR_WIDTH=6, DATA_WIDTH=32.
REQ-021 The scoreboard (busy vector, set/clear, effective-busy lookup for three ports) SHALL be the sub-module `scoreboard`; the handshake and output register SHALL stay in operand_fetch.

Verification
REQ-022 The bench SHALL cover these scenarios (stimulus -> required response):
- Reset, then accept rs1=3, rs2=4, rd=5 with read_data=0x11/0x22 -> next cycle out_valid=1, operands 0x11/0x22, busy[5]=1.
- RAW: rd=5 outstanding, next instruction rs1=5 -> in_ready=0 until wb_valid with wb_rd=5, wb_data=0xDEAD; in that cycle accept, out_operand_1=0xDEAD.
- rs1=0, rs2=0, rd=0 with read_data=0xFFFF_FFFF -> operands 0/0, out_rd_write=0, no busy bit set.
- out_ready=0 for 3 cycles with in_valid=1 -> bundle held stable, in_ready=0; out_ready=1 -> next bundle follows with no bubble.
- Same edge: accept with rd=7 and wb_valid with wb_rd=7 -> busy[7]=1 afterwards.
- Reset asserted during a stall with busy[9]=1 -> out_valid=0 and busy=0 after the edge; a subsequent instruction with rs1=9 is accepted immediately.
